mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch requester and the data (load/store) requester.
- Sits between pipeline fetch/memory stages and the unified memory.
- Serialises transactions and returns per-requester done pulses with read data.
- Supports cancelling an in-flight fetch on a late branch.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- STREAK_MAX, 3, maximum consecutive data grants while fetch waits (fairness feature only); legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  fetch read request; held until fetch_done or fetch_cancel.
- fetch_addr  in  ADDR_W  fetch address; sampled at grant.
- fetch_cancel  in  1  late-branch flush; discards the pending or in-flight fetch result.
- fetch_done  out  1  one-cycle pulse; fetch_rdata valid.
- fetch_rdata  out  DATA_W  fetched word.
- data_req  in  1  data request; held until data_done.
- data_we  in  1  1 = write, 0 = read; sampled at grant.
- data_addr  in  ADDR_W  data address; sampled at grant.
- data_wdata  in  DATA_W  write data; sampled at grant.
- data_done  out  1  one-cycle pulse; data_rdata valid (reads).
- data_rdata  out  DATA_W  loaded word.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: all outputs 0; state IDLE; drop flag 0; streak counter 0.
- FSM states: IDLE, F_BUSY, D_BUSY.
- IDLE:
  - data_req → latch we/addr/wdata, go D_BUSY.
  - else fetch_req & !fetch_cancel → latch addr, mem_we=0, go F_BUSY.
  - Data has priority over fetch.
- F_BUSY/D_BUSY:
  - mem_req=1 and mem_* stable until mem_ack.
  - On mem_ack: next edge go IDLE, mem_req=0, and pulse the owner's done with rdata registered from mem_rdata.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req high at cycle 1.
  - mem_ack at cycle k → done at k+1.
  - Next grant is possible at k+1 (mem_req at k+2).
  - Minimum turnaround is 2 cycles per transaction.
- Write: data_done pulses; data_rdata holds its previous value.
- fetch_cancel in F_BUSY (or in the ack cycle): set drop flag. The memory transaction still completes, fetch_done is suppressed, and fetch_rdata is unchanged. The drop flag clears on return to IDLE.
- fetch_cancel in IDLE: no fetch grant that cycle.
- Simultaneous data_req and fetch_req in IDLE: data wins (subject to the fairness feature).
- A requester dropping req before done is illegal; the transaction completes regardless.
- Reset mid-transaction: mem_req drops asynchronously, the transaction is abandoned, and no done pulse is issued.
- fetch_rdata/data_rdata update only on their respective done pulses.

Optional Feature:
- Macro MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 4-bit streak counter increments on each data grant made while fetch_req & !fetch_cancel.
  - Any fetch grant resets it to 0.
  - When streak == STREAK_MAX and the fetch request is valid in IDLE, fetch wins over data.
  - The counter saturates at STREAK_MAX.
- Undefined: strict data priority, no counter logic; fetch may starve indefinitely.

Decomposition:
- Shared package: state encoding constants (ARB_IDLE=2'd0, ARB_F_BUSY=2'd1, ARB_D_BUSY=2'd2) and the default widths.
- One natural sub-module: arb_grant_sel, the combinational-plus-streak-counter grant decision; it is instantiated once.
- FSM, latches and return path stay in the top module.

Test Plan:
- Fetch only: fetch_addr=0x100, mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, fetch_done 1 cycle after ack, fetch_rdata=0xDEADBEEF, data_done never.
- Simultaneous fetch_req and data_req (read 0x200): → data granted first; fetch granted in the cycle data_done pulses; mem_addr sequence 0x200 then fetch address.
- Store: data_we=1, data_addr=0x40, data_wdata=0x12345678, ack after 1 cycle → mem_we=1 with the stored values; data_done pulse; data_rdata unchanged.
- Cancel: fetch in F_BUSY, pulse fetch_cancel 1 cycle, ack 2 cycles later → no fetch_done, fetch_rdata unchanged; a following fetch completes normally.
- Fairness (macro on, STREAK_MAX=3): data_req and fetch_req both held high → grant order D, D, D, F, D…; with macro off → all D until data_req drops.
- Reset asserted while D_BUSY awaits ack → mem_req=0 immediately, all outputs 0; after release, IDLE with no spurious done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and default widths for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STREAK_MAX = 3;
    localparam int STREAK_W       = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_F_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// rtl/mem_port_arbiter_grant_sel.sv - fetch/data grant decision with optional streak fairness (MEM_ARB_FAIRNESS_EN)
module arb_grant_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STREAK_MAX = DEF_STREAK_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_data_req,
    input  logic i_fetch_req,
    input  logic i_fetch_cancel,
    output logic o_grant_data,
    output logic o_grant_fetch
);

    // A cancelled fetch is never a candidate for a grant.
    logic w_fetch_valid;
    assign w_fetch_valid = i_fetch_req & ~i_fetch_cancel;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [STREAK_W-1:0] r_streak;
    logic                w_fetch_turn;

    assign w_fetch_turn = (r_streak == STREAK_W'(STREAK_MAX)) & w_fetch_valid;

    // Data wins unless fetch has waited through STREAK_MAX data grants.
    always_comb begin
        o_grant_data  = i_idle & i_data_req & ~w_fetch_turn;
        o_grant_fetch = i_idle & w_fetch_valid & ~o_grant_data;
    end

    // Count data grants that overtook a waiting fetch; saturate, clear on fetch grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (o_grant_fetch) begin
            r_streak <= '0;
        end else if (o_grant_data && w_fetch_valid && (r_streak != STREAK_W'(STREAK_MAX))) begin
            r_streak <= r_streak + 1'b1;
        end
    end
`else
    // Strict data priority; fetch only gets the port when data is quiet.
    assign o_grant_data  = i_idle & i_data_req;
    assign o_grant_fetch = i_idle & w_fetch_valid & ~i_data_req;

    logic w_unused;
    assign w_unused = ^{clk, rst, STREAK_W'(STREAK_MAX)};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one variable-latency memory port (option: MEM_ARB_FAIRNESS_EN)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STREAK_MAX = DEF_STREAK_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_cancel,
    output logic              fetch_done,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_done,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    logic              r_drop;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_fetch_done;
    logic [DATA_W-1:0] r_fetch_rdata;
    logic              r_data_done;
    logic [DATA_W-1:0] r_data_rdata;

    logic w_idle;
    logic w_grant_data;
    logic w_grant_fetch;

    assign w_idle = (r_state == ARB_IDLE);

    arb_grant_sel #(
        .STREAK_MAX(STREAK_MAX)
    ) u_grant_sel (
        .clk           (clk),
        .rst           (rst),
        .i_idle        (w_idle),
        .i_data_req    (data_req),
        .i_fetch_req   (fetch_req),
        .i_fetch_cancel(fetch_cancel),
        .o_grant_data  (w_grant_data),
        .o_grant_fetch (w_grant_fetch)
    );

    // Arbitration FSM: latch the winner's request, hold it on the port until ack, return data with a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ARB_IDLE;
            r_drop        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fetch_done  <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_done   <= 1'b0;
            r_data_rdata  <= '0;
        end else begin
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_data) begin
                        r_state     <= ARB_D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= data_we;
                        r_mem_addr  <= data_addr;
                        r_mem_wdata <= data_wdata;
                    end else if (w_grant_fetch) begin
                        r_state    <= ARB_F_BUSY;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= fetch_addr;
                    end
                end
                ARB_F_BUSY: begin
                    // A late branch only discards the result; the memory cycle itself runs to completion.
                    if (fetch_cancel) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        if (!r_drop && !fetch_cancel) begin
                            r_fetch_done  <= 1'b1;
                            r_fetch_rdata <= mem_rdata;
                        end
                    end
                end
                ARB_D_BUSY: begin
                    if (mem_ack) begin
                        r_state     <= ARB_IDLE;
                        r_mem_req   <= 1'b0;
                        r_data_done <= 1'b1;
                        if (!r_mem_we) begin
                            r_data_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_mem_req <= 1'b0;
                    r_drop    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign fetch_done  = r_fetch_done;
    assign fetch_rdata = r_fetch_rdata;
    assign data_done   = r_data_done;
    assign data_rdata  = r_data_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (expects MEM_ARB_FAIRNESS_EN as the DUT build)
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_cancel = 1'b0;
    logic        fetch_done;
    logic [31:0] fetch_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_done;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fd    = 0;
    int n_dd    = 0;

    typedef struct {
        logic        is_data;
        logic        we;
        logic        cancel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_fd;
        logic        exp_dd;
        logic [31:0] exp_frd;
        logic [31:0] exp_drd;
    } vec_t;

    vec_t vecs[7];

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STREAK_MAX(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_cancel(fetch_cancel),
        .fetch_done  (fetch_done),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_done   (data_done),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (fetch_done) n_fd++;
        if (data_done) n_dd++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_grant_timeout"}, {63'd0, mem_req}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        n_fd = 0;
        n_dd = 0;
        if (v.is_data) begin
            data_req   = 1'b1;
            data_we    = v.we;
            data_addr  = v.addr;
            data_wdata = v.wdata;
        end else begin
            fetch_req  = 1'b1;
            fetch_addr = v.addr;
        end
        tick();
        check({p, "_req_latency"}, {63'd0, mem_req}, 64'd1);
        check({p, "_mem_we"}, {63'd0, mem_we}, {63'd0, v.we});
        check({p, "_mem_addr"}, {32'd0, mem_addr}, {32'd0, v.addr});
        if (v.we) check({p, "_mem_wdata"}, {32'd0, mem_wdata}, {32'd0, v.wdata});
        for (int i = 0; i < v.delay; i++) begin
            if (v.cancel && i == 0) begin
                fetch_cancel = 1'b1;
                fetch_req    = 1'b0;
            end
            tick();
            fetch_cancel = 1'b0;
        end
        check({p, "_held_at_ack"}, {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, v.addr});
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check({p, "_fetch_done"}, {63'd0, fetch_done}, {63'd0, v.exp_fd});
        check({p, "_data_done"}, {63'd0, data_done}, {63'd0, v.exp_dd});
        check({p, "_fetch_rdata"}, {32'd0, fetch_rdata}, {32'd0, v.exp_frd});
        check({p, "_data_rdata"}, {32'd0, data_rdata}, {32'd0, v.exp_drd});
        check({p, "_req_drop"}, {63'd0, mem_req}, 64'd0);
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        tick();
        tick();
        check({p, "_pulse_counts"}, {32'(n_fd), 32'(n_dd)}, {31'd0, v.exp_fd, 31'd0, v.exp_dd});
        check({p, "_idle_after"}, {63'd0, mem_req}, 64'd0);
    endtask

    initial begin
        logic [5:0] order;
        logic [5:0] exp_order;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h040, 32'h12345678, 32'hBAD0BAD0, 1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h0,        32'hCAFEF00D, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h104, 32'h0,        32'h11111111, 2, 1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h108, 32'h0,        32'h22222222, 1, 1'b1, 1'b0, 32'h22222222, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h044, 32'hA5A5A5A5, 32'h99999999, 2, 1'b0, 1'b1, 32'h22222222, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0,        32'h0F0F0F0F, 4, 1'b0, 1'b1, 32'h22222222, 32'h0F0F0F0F};

        // Reset state
        tick();
        tick();
        check("reset_outputs_zero",
              {63'd0, |{mem_req, mem_we, mem_addr, mem_wdata, fetch_done, fetch_rdata, data_done, data_rdata}}, 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Simultaneous requests: data first, fetch granted in the data_done cycle
        n_fd = 0;
        n_dd = 0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h500;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h200;
        tick();
        check("sim_first_addr", {32'd0, mem_addr}, {32'd0, 32'h200});
        check("sim_first_req", {63'd0, mem_req}, 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h33333333;
        tick();
        mem_ack  = 1'b0;
        data_req = 1'b0;
        check("sim_data_done", {32'd0, data_done, data_rdata}, {31'd0, 1'b1, 32'h33333333});
        tick();
        check("sim_fetch_grant", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h500});
        mem_ack   = 1'b1;
        mem_rdata = 32'h44444444;
        tick();
        mem_ack   = 1'b0;
        fetch_req = 1'b0;
        check("sim_fetch_done", {32'd0, fetch_done, fetch_rdata}, {31'd0, 1'b1, 32'h44444444});
        tick();

        // Both requests held: grant order depends on the fairness build
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 32'h600;
        fetch_req  = 1'b1;
        fetch_addr = 32'h700;
        order = '0;
        for (int g = 0; g < 6; g++) begin
            wait_grant($sformatf("fair_g%0d", g));
            order[5-g] = (mem_addr == 32'h700);
            mem_ack   = 1'b1;
            mem_rdata = 32'h66660000 + 32'(g);
            tick();
            mem_ack = 1'b0;
        end
`ifdef MEM_ARB_FAIRNESS_EN
        exp_order = 6'b000100;
`else
        exp_order = 6'b000000;
`endif
        check("fair_order", {58'd0, order}, {58'd0, exp_order});
        data_req = 1'b0;
        tick();
        check("fair_fetch_after_drop", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h700});
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        mem_ack   = 1'b0;
        fetch_req = 1'b0;
        check("fair_fetch_done", {32'd0, fetch_done, fetch_rdata}, {31'd0, 1'b1, 32'h77777777});
        tick();

        // Cancel while IDLE blocks the fetch grant for that cycle only
        fetch_req    = 1'b1;
        fetch_addr   = 32'h900;
        fetch_cancel = 1'b1;
        tick();
        fetch_cancel = 1'b0;
        check("idle_cancel_no_grant", {63'd0, mem_req}, 64'd0);
        tick();
        check("idle_cancel_then_grant", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h900});
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        mem_ack   = 1'b0;
        fetch_req = 1'b0;
        check("idle_cancel_done", {32'd0, fetch_done, fetch_rdata}, {31'd0, 1'b1, 32'h55555555});
        tick();

        // Reset while D_BUSY waits for ack
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h800;
        tick();
        check("rst_mid_busy", {63'd0, mem_req}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outputs",
              {63'd0, |{mem_req, mem_we, mem_addr, mem_wdata, fetch_done, fetch_rdata, data_done, data_rdata}}, 64'd0);
        tick();
        data_req = 1'b0;
        rst  = 1'b1;
        n_fd = 0;
        n_dd = 0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hEEEEEEEE;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        check("rst_no_spurious_done", {32'(n_fd), 32'(n_dd)}, 64'd0);
        check("rst_idle_after", {31'd0, mem_req, data_rdata}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
